sprite_loader: RTL and testbench
================================

SPRITE_LOADER -- requirements
Module: sprite_loader

Interface
REQ-001 SHALL have ports: clk  in  1  system clock (pixel clock domain of the sprite controllers).
REQ-002 SHALL have: rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 SHALL have: start  in  1  one-cycle request to begin a load.
REQ-004 SHALL have: base_addr  in  12  first sprite-RAM word address of the load, sampled on accepted start.
REQ-005 SHALL have: length  in  12  number of words to write, sampled on accepted start; 0 is legal.
REQ-006 SHALL have: vblank  in  1  high while the raster is outside the active area; the only window in which RAM writes occur.
REQ-007 SHALL have: in_valid  in  1  and  in_data  in  8  for the source pixel stream.
REQ-008 SHALL have: in_ready  out  1  stream back-pressure; a beat transfers when in_valid and in_ready are both high.
REQ-009 SHALL have: wr_addr  out  12,  wr_data  out  8,  wr_en  out  1  for the sprite-RAM write port.
REQ-010 SHALL have: busy  out  1,  done  out  1  (one-cycle pulse),  checksum  out  16.

Function
REQ-011 SHALL implement states IDLE, WAIT_BLANK, WRITE, DONE.
REQ-012 IDLE: start=1 latches base_addr/length, clears word counter, goes to WAIT_BLANK; if length=0 goes directly to DONE.
REQ-013 WAIT_BLANK: in_ready=0; moves to WRITE on the first cycle vblank=1.
REQ-014 WRITE: in_ready = vblank; each transferred beat is written one cycle later: wr_en=1, wr_data=beat, wr_addr=base_addr+index.
REQ-015 WRITE: vblank falling mid-load returns to WAIT_BLANK with counter kept; a beat transferred on the last vblank cycle is still written in the following cycle.
REQ-016 WRITE: the transfer of beat length-1 moves to DONE; in_ready=0 from the next cycle.
REQ-017 DONE: done=1 for exactly one cycle (the cycle the final wr_en is high, or the cycle after start for length=0), then IDLE.
REQ-018 Address arithmetic SHALL be 12-bit modulo: base_addr+index beyond 4095 wraps to 0 with no error.
REQ-019 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored.
REQ-020 in_valid=0 during WRITE SHALL stall without penalty; wr_en=0 in cycles after a non-transfer.
REQ-021 wr_en SHALL never be 1 in a cycle following one with vblank=0 and no transfer.

Reset
REQ-022 On rst_n=0: state IDLE, wr_en=0, wr_addr=0, wr_data=0, in_ready=0, busy=0, done=0, checksum=0, counter=0.
REQ-023 Reset asserted mid-load SHALL abort immediately; a beat transferred in the reset cycle SHALL NOT be written.

Configuration
REQ-024 Macro SPRITE_LOADER_CHECKSUM_EN defined: checksum = 16-bit wrapping sum of all bytes written in the current load, cleared on accepted start, stable from done until next start.
REQ-025 Macro SPRITE_LOADER_CHECKSUM_EN undefined: checksum tied to 0, no adder instantiated.

Structure
REQ-026 Sprite-RAM address width (12) and data width (8) SHALL come from define.v as shared constants, alongside the existing sprite geometry defines; state encodings SHALL be local.
REQ-027 Single module; no sub-module; RAM external, shared via its write port with the sprite controllers' read port.

Verification
REQ-028 Reset, start base=0x100 length=4, vblank=1, data 0x11,0x22,0x33,0x44 back-to-back -> wr_en on 4 consecutive cycles, addr 0x100..0x103, done with last write, checksum 0x00AA (when enabled).
REQ-029 base=0xFFE length=4 -> addresses 0xFFE,0xFFF,0x000,0x001.
REQ-030 length=8, vblank drops after beat 3 for 20 cycles -> in_ready=0, no wr_en during gap; beats 4..7 to base+4..base+7 after vblank returns.
REQ-031 start with vblank=0 -> state WAIT_BLANK, in_ready=0 until vblank=1; second start while busy ignored (base unchanged).
REQ-032 length=0 -> no wr_en, done pulse one cycle after start, busy low afterwards.
REQ-033 rst_n=0 after beat 2 of 6 -> all outputs at reset values next cycle, no further writes, new start accepted normally.

Source files
------------

// File: rtl/sprite_loader_pkg.sv
// -----------------------------------------------------------------------------
// sprite_loader_pkg
//
// Shared sprite-RAM constants and types for the sprite subsystem.
//   SPR_ADDR_W : sprite-RAM word address width (12 -> 4096 words)
//   SPR_DATA_W : sprite-RAM word width (8-bit pixel bytes)
//   SPR_SUM_W  : width of the load checksum reported by sprite_loader
//
// The loader's state encoding is deliberately kept local to sprite_loader.
// The optional checksum adder is enabled with SPRITE_LOADER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
package sprite_loader_pkg;

    localparam int SPR_ADDR_W = 12;
    localparam int SPR_DATA_W = 8;
    localparam int SPR_SUM_W  = 16;

    typedef logic [SPR_ADDR_W-1:0] spr_addr_t;
    typedef logic [SPR_DATA_W-1:0] spr_data_t;
    typedef logic [SPR_SUM_W-1:0]  spr_sum_t;

    // Wrapping byte accumulate used by the load checksum.
    function automatic spr_sum_t sum_add(input spr_sum_t acc, input spr_data_t b);
        return acc + spr_sum_t'(b);
    endfunction

endpackage : sprite_loader_pkg

// File: rtl/sprite_loader_if.sv
// -----------------------------------------------------------------------------
// sprite_loader_if
//
// Bundles the sprite loader's request, pixel stream, RAM write port and
// status signals.
//   master : the requester / stream source / environment (drives start,
//            base_addr, length, vblank, in_valid, in_data)
//   slave  : the sprite_loader itself (drives in_ready, wr_*, busy, done,
//            checksum)
// clk and rst_n are not part of the bundle; they stay plain module ports.
// -----------------------------------------------------------------------------
interface sprite_loader_if;
    import sprite_loader_pkg::*;

    // Load request
    logic      start;
    spr_addr_t base_addr;
    spr_addr_t length;

    // Raster timing
    logic      vblank;

    // Source pixel stream
    logic      in_valid;
    spr_data_t in_data;
    logic      in_ready;

    // Sprite-RAM write port
    spr_addr_t wr_addr;
    spr_data_t wr_data;
    logic      wr_en;

    // Status
    logic      busy;
    logic      done;
    spr_sum_t  checksum;

    modport master (
        output start, base_addr, length, vblank, in_valid, in_data,
        input  in_ready, wr_addr, wr_data, wr_en, busy, done, checksum
    );

    modport slave (
        input  start, base_addr, length, vblank, in_valid, in_data,
        output in_ready, wr_addr, wr_data, wr_en, busy, done, checksum
    );

endinterface : sprite_loader_if

// File: rtl/sprite_loader.sv
// -----------------------------------------------------------------------------
// sprite_loader
//
// Copies a stream of pixel bytes into the external sprite RAM, writing only
// while the raster is in vertical blank so the sprite controllers' read port
// never sees a half-updated sprite during active video.
//
// Ports:
//   clk    : pixel clock of the sprite controllers
//   rst_n  : synchronous, active-low reset (sampled on rising clk)
//   bus    : sprite_loader_if.slave
//            start/base_addr/length : load request, sampled when accepted
//            vblank                 : write window
//            in_valid/in_data/in_ready : source stream (beat on valid&ready)
//            wr_addr/wr_data/wr_en  : sprite-RAM write port, one cycle after
//                                     the beat transferred
//            busy/done/checksum     : status; done pulses with the last write
//
// Configuration:
//   SPRITE_LOADER_CHECKSUM_EN defined   : checksum is the 16-bit wrapping sum
//                                         of the bytes of the current load.
//   SPRITE_LOADER_CHECKSUM_EN undefined : checksum tied to zero, no adder.
// -----------------------------------------------------------------------------
module sprite_loader
    import sprite_loader_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    sprite_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_BLANK = 2'd1,
        WRITE      = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t    state_q;
    state_t    state_d;

    spr_addr_t base_q;      // first word address of the current load
    spr_addr_t len_q;       // number of words in the current load
    spr_addr_t idx_q;       // index of the next beat to accept

    logic      wr_en_q;
    spr_addr_t wr_addr_q;
    spr_data_t wr_data_q;

    logic      start_ok;    // request accepted this cycle
    logic      xfer;        // stream beat transfers this cycle
    logic      last_beat;   // the transferring beat is the final one

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    // Ready is also gated by rst_n so a beat offered in the reset cycle is
    // never accepted, leaving the source to present it again later.
    assign bus.in_ready = rst_n && (state_q == WRITE) && bus.vblank;
    assign xfer         = bus.in_valid && bus.in_ready;
    assign start_ok     = (state_q == IDLE) && bus.start;
    assign last_beat    = xfer && (idx_q == (len_q - spr_addr_t'(1)));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and status outputs
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        bus.busy = 1'b1;
        bus.done = 1'b0;

        case (state_q)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    // An empty load has nothing to wait for.
                    state_d = (bus.length == '0) ? DONE : WAIT_BLANK;
                end
            end

            WAIT_BLANK: begin
                if (bus.vblank) begin
                    state_d = WRITE;
                end
            end

            WRITE: begin
                // last_beat implies vblank, so it takes priority safely.
                if (last_beat) begin
                    state_d = DONE;
                end else if (!bus.vblank) begin
                    state_d = WAIT_BLANK;
                end
            end

            DONE: begin
                // Coincides with the final RAM write (registered one cycle
                // after the last beat), or the cycle after an empty start.
                bus.done = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Load context and RAM write port
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            // A write happens exactly in the cycle after a transfer and never
            // otherwise, so stalls and blanking gaps produce no writes.
            wr_en_q <= xfer;

            if (start_ok) begin
                base_q <= bus.base_addr;
                len_q  <= bus.length;
                idx_q  <= '0;
            end else if (xfer) begin
                idx_q     <= idx_q + spr_addr_t'(1);
                // 12-bit add wraps past the top of sprite RAM by design.
                wr_addr_q <= base_q + idx_q;
                wr_data_q <= bus.in_data;
            end
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

    // -------------------------------------------------------------------------
    // Optional load checksum
    // -------------------------------------------------------------------------
`ifdef SPRITE_LOADER_CHECKSUM_EN
    spr_sum_t sum_q;

    // Accumulating on the transfer makes the sum complete in the same cycle
    // as the final write and done, and it then holds until the next start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (start_ok) begin
            sum_q <= '0;
        end else if (xfer) begin
            sum_q <= sum_add(sum_q, bus.in_data);
        end
    end

    assign bus.checksum = sum_q;
`else
    assign bus.checksum = '0;
`endif

endmodule : sprite_loader

// File: tb/tb_sprite_loader.sv
// -----------------------------------------------------------------------------
// tb_sprite_loader
//
// Self-checking bench for sprite_loader. Each load is described as a list of
// bytes; the expected RAM image is base+i (mod 4096) <- byte i, the expected
// checksum is the wrapping sum of the bytes (zero without
// SPRITE_LOADER_CHECKSUM_EN), a write must appear exactly one cycle after
// each stream transfer, and done must coincide with the write of the final
// byte. Random request pulses are injected while busy to show they are
// ignored.
// -----------------------------------------------------------------------------
module tb_sprite_loader;
    import sprite_loader_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sprite_loader_if bus ();

    sprite_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] beats[$];

    // -------------------------------------------------------------------------
    // Reference helpers
    // -------------------------------------------------------------------------
    task automatic fill_beats(input int n);
        beats.delete();
        for (int i = 0; i < n; i++) beats.push_back(8'($urandom));
    endtask

    function automatic logic [15:0] model_checksum();
        logic [15:0] s;
        s = 16'h0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
        foreach (beats[i]) s = s + 16'(beats[i]);
`endif
        return s;
    endfunction

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.base_addr = 12'h0;
        bus.length    = 12'h0;
        bus.vblank    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h0;
    endtask

    // -------------------------------------------------------------------------
    // Generic load driver + checker.
    //   pre_blank : cycles of vblank=0 starting with the start cycle
    //   gap_after : after beat gap_after has transferred, vblank=0 for gap_len
    //   rnd       : random in_valid and random vblank drops
    // -------------------------------------------------------------------------
    task automatic run_load(input string name, input logic [11:0] base,
                            input int pre_blank, input int gap_after,
                            input int gap_len, input bit rnd);
        int          len;
        int          sent;
        int          written;
        int          cyc;
        int          gap_left;
        bit          gap_done;
        bit          prev_xfer;
        bit          finished;
        bit          exp_done;
        logic        vb;
        logic [11:0] exp_addr;
        logic [15:0] exp_sum;

        len       = beats.size();
        sent      = 0;
        written   = 0;
        cyc       = 0;
        gap_left  = 0;
        gap_done  = 1'b0;
        finished  = 1'b0;
        exp_sum   = model_checksum();

        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.length    = 12'(len);
        bus.vblank    = (pre_blank == 0);
        bus.in_valid  = 1'b1;
        bus.in_data   = beats[0];
        #1;
        prev_xfer = bus.in_valid && (bus.in_ready === 1'b1);
        if (prev_xfer) sent++;

        while (!finished && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            exp_done = prev_xfer && (sent == len);

            checks++;
            if (bus.wr_en !== prev_xfer) begin
                errors++;
                $display("FAIL %s wr_en cycle %0d: got %b expected %b", name, cyc, bus.wr_en, prev_xfer);
            end
            if (bus.wr_en === 1'b1 && written < len) begin
                exp_addr = base + 12'(written);
                checks++;
                if (bus.wr_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL %s wr_addr beat %0d: got %03h expected %03h", name, written, bus.wr_addr, exp_addr);
                end
                checks++;
                if (bus.wr_data !== beats[written]) begin
                    errors++;
                    $display("FAIL %s wr_data beat %0d: got %02h expected %02h", name, written, bus.wr_data, beats[written]);
                end
                written++;
            end
            checks++;
            if (bus.done !== exp_done) begin
                errors++;
                $display("FAIL %s done cycle %0d: got %b expected %b", name, cyc, bus.done, exp_done);
            end
            checks++;
            if (bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b expected 1", name, cyc, bus.busy);
            end
            if (exp_done || bus.done === 1'b1) begin
                finished = 1'b1;
                checks++;
                if (written != len) begin
                    errors++;
                    $display("FAIL %s write count: got %0d expected %0d", name, written, len);
                end
                checks++;
                if (bus.checksum !== exp_sum) begin
                    errors++;
                    $display("FAIL %s checksum at done: got %04h expected %04h", name, bus.checksum, exp_sum);
                end
            end

            // Stray requests while busy must be ignored.
            if (!finished && $urandom_range(0, 3) == 0) begin
                bus.start     = 1'b1;
                bus.base_addr = 12'($urandom);
                bus.length    = 12'($urandom);
            end else begin
                bus.start = 1'b0;
            end

            if (!gap_done && gap_after >= 0 && sent == gap_after + 1) begin
                gap_left = gap_len;
                gap_done = 1'b1;
            end
            if (cyc < pre_blank) begin
                vb = 1'b0;
            end else if (gap_left > 0) begin
                vb = 1'b0;
                gap_left--;
            end else begin
                vb = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
            end
            bus.vblank   = vb;
            bus.in_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.in_data  = (sent < len) ? beats[sent] : 8'($urandom);
            #1;
            if (!vb || sent >= len) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s in_ready cycle %0d: got %b expected 0 (vblank %b, sent %0d)", name, cyc, bus.in_ready, vb, sent);
                end
            end
            prev_xfer = bus.in_valid && (bus.in_ready === 1'b1);
            if (prev_xfer) sent++;
        end

        if (!finished) begin
            errors++;
            $display("FAIL %s timeout: got %0d writes expected %0d", name, written, len);
        end

        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy after done: got %b expected 0", name, bus.busy);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL %s done width: got %b expected 0", name, bus.done);
        end
        checks++;
        if (bus.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL %s wr_en after done: got %b expected 0", name, bus.wr_en);
        end
        checks++;
        if (bus.checksum !== exp_sum) begin
            errors++;
            $display("FAIL %s checksum after done: got %04h expected %04h", name, bus.checksum, exp_sum);
        end
        bus.vblank = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic check_reset_values(input string name);
        checks++;
        if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL %s wr_en: got %b expected 0", name, bus.wr_en); end
        checks++;
        if (bus.wr_addr !== 12'h0) begin errors++; $display("FAIL %s wr_addr: got %03h expected 000", name, bus.wr_addr); end
        checks++;
        if (bus.wr_data !== 8'h0) begin errors++; $display("FAIL %s wr_data: got %02h expected 00", name, bus.wr_data); end
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL %s in_ready: got %b expected 0", name, bus.in_ready); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %b expected 0", name, bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL %s done: got %b expected 0", name, bus.done); end
        checks++;
        if (bus.checksum !== 16'h0) begin errors++; $display("FAIL %s checksum: got %04h expected 0000", name, bus.checksum); end
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.vblank   = 1'b1;
        bus.in_valid = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        idle_inputs();
    endtask

    task automatic test_basic();
        beats.delete();
        beats.push_back(8'h11);
        beats.push_back(8'h22);
        beats.push_back(8'h33);
        beats.push_back(8'h44);
        run_load("basic", 12'h100, 0, -1, 0, 1'b0);
    endtask

    task automatic test_wrap();
        fill_beats(4);
        run_load("wrap", 12'hFFE, 0, -1, 0, 1'b0);
    endtask

    task automatic test_vblank_gap();
        fill_beats(8);
        run_load("vblank_gap", 12'($urandom), 0, 3, 20, 1'b0);
    endtask

    task automatic test_wait_blank();
        fill_beats(5);
        run_load("wait_blank", 12'($urandom), 8, -1, 0, 1'b0);
    endtask

    task automatic test_len_zero();
        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = 12'($urandom);
        bus.length    = 12'h0;
        bus.vblank    = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'($urandom);
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL len_zero done: got %b expected 1", bus.done); end
        checks++;
        if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL len_zero wr_en: got %b expected 0", bus.wr_en); end
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL len_zero in_ready: got %b expected 0", bus.in_ready); end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL len_zero done width: got %b expected 0", bus.done); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL len_zero busy after: got %b expected 0", bus.busy); end
        checks++;
        if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL len_zero wr_en after: got %b expected 0", bus.wr_en); end
        checks++;
        if (bus.checksum !== 16'h0) begin errors++; $display("FAIL len_zero checksum: got %04h expected 0000", bus.checksum); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        int  sent;
        bit  hit;
        fill_beats(6);
        sent = 0;
        hit  = 1'b0;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = 12'($urandom);
        bus.length    = 12'd6;
        bus.vblank    = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = beats[0];
        for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (sent == 2) begin
                bus.in_data = beats[2];
                rst_n       = 1'b0;
                hit         = 1'b1;
            end else begin
                bus.in_data = beats[sent];
                #1;
                if (bus.in_valid && bus.in_ready === 1'b1) sent++;
            end
        end
        if (!hit) begin
            errors++;
            $display("FAIL reset_mid timeout: got %0d beats expected 2", sent);
            rst_n = 1'b0;
        end
        @(negedge clk);
        check_reset_values("reset_mid");
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (bus.wr_en !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid stray write cycle %0d: got %b expected 0", c, bus.wr_en);
            end
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            fill_beats($urandom_range(1, 12));
            run_load("back_to_back", 12'($urandom), 0, -1, 0, 1'b0);
        end
    endtask

    task automatic test_random();
        int n;
        for (int i = 0; i < 8; i++) begin
            n = $urandom_range(1, 24);
            fill_beats(n);
            run_load("random", 12'($urandom), $urandom_range(0, 5),
                     $urandom_range(0, 1) ? int'($urandom_range(0, n - 1)) : -1,
                     $urandom_range(1, 10), 1'b1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_basic();
        test_wrap();
        test_vblank_gap();
        test_wait_blank();
        test_len_zero();
        test_reset_mid();
        test_basic();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sprite_loader
